// File: rtl/d_branch_pkg.sv
// Shared types and constants for the D-stage branch controller.
package d_branch_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0] FWD_GRF = 2'd0;
  localparam logic [SEL_W-1:0] FWD_E   = 2'd1;
  localparam logic [SEL_W-1:0] FWD_M   = 2'd2;

  localparam logic [OP_W-1:0] CMP_NONE = 4'd0;

  // Forwarding source for one operand; E wins over M, and r0 always reads the GRF.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic [REG_W-1:0]  r,
    input logic [REG_W-1:0]  e_wa,
    input logic [TNEW_W-1:0] e_tnew,
    input logic [REG_W-1:0]  m_wa,
    input logic [TNEW_W-1:0] m_tnew
  );
    logic [SEL_W-1:0] sel;
    sel = FWD_GRF;
    if (r != REG_W'(0)) begin
      if (e_wa == r && e_tnew == TNEW_W'(0)) begin
        sel = FWD_E;
      end else if (m_wa == r && m_tnew == TNEW_W'(0)) begin
        sel = FWD_M;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/d_branch_ctrl_d_hazard_need.sv
// Combinational RAW hazard check: stall need (clipped) and operand forwarding selects.
module d_hazard_need
  import d_branch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 2,
  parameter int unsigned CNT_W    = 2
) (
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  input  logic [REG_W-1:0]  e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [REG_W-1:0]  m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  output logic [CNT_W-1:0]  need,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b
);

  logic              e_hit;
  logic              m_hit;
  logic [TNEW_W-1:0] raw;

  always_comb begin
    e_hit = (e_wa != REG_W'(0)) && (e_wa == rs_addr || e_wa == rt_addr);
    m_hit = (m_wa != REG_W'(0)) && (m_wa == rs_addr || m_wa == rt_addr);
    raw   = '0;
    if (e_hit) raw = e_tnew;
    if (m_hit && m_tnew > raw) raw = m_tnew;
    if (32'(raw) > MAX_WAIT) need = CNT_W'(MAX_WAIT);
    else                     need = CNT_W'(raw);
  end

  always_comb begin
    fwd_sel_a = fwd_pick(rs_addr, e_wa, e_tnew, m_wa, m_tnew);
    fwd_sel_b = fwd_pick(rt_addr, e_wa, e_tnew, m_wa, m_tnew);
  end

endmodule

// File: rtl/d_branch_ctrl.sv
// D-stage branch sequencer: stalls on compare-operand hazards, then enables the comparator.
// Optional stall/taken statistics counters are built when D_BRANCH_CTRL_STATS_EN is defined.
module d_branch_ctrl
  import d_branch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 2,
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [OP_W-1:0]   d_cmp_op,
  input  logic [REG_W-1:0]  d_rs_addr,
  input  logic [REG_W-1:0]  d_rt_addr,
  input  logic [REG_W-1:0]  e_wa,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic [REG_W-1:0]  m_wa,
  input  logic [TNEW_W-1:0] m_tnew,
  input  logic              flush,
  input  logic              cmp_branch,
  output logic              cmp_en,
  output logic [OP_W-1:0]   cmp_op_o,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
`ifdef D_BRANCH_CTRL_STATS_EN
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] taken_cnt,
`endif
  output logic              redirect
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] need;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             live;
  logic             stall_int;
  logic             cmp_int;

  d_hazard_need #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_need (
    .rs_addr   (d_rs_addr),
    .rt_addr   (d_rt_addr),
    .e_wa      (e_wa),
    .e_tnew    (e_tnew),
    .m_wa      (m_wa),
    .m_tnew    (m_tnew),
    .need      (need),
    .fwd_sel_a (sel_a),
    .fwd_sel_b (sel_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flushed or vanished branch abandons any wait and returns to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    cmp_int   = 1'b0;
    live      = d_valid && (d_cmp_op != CMP_NONE) && !flush;
    case (state_q)
      ST_IDLE: begin
        if (live) begin
          if (need == CNT_W'(0)) begin
            cmp_int = 1'b1;
          end else begin
            stall_int = 1'b1;
            cnt_d     = need - CNT_W'(1);
            state_d   = (need == CNT_W'(1)) ? ST_RESOLVE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!live) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall_int = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RESOLVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_RESOLVE: begin
        state_d = ST_IDLE;
        cmp_int = live;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset forces every output low without waiting for a clock edge.
  always_comb begin
    stall     = reset_n & stall_int;
    cmp_en    = reset_n & cmp_int;
    cmp_op_o  = cmp_en ? d_cmp_op : CMP_NONE;
    redirect  = cmp_en & cmp_branch;
    fwd_sel_a = reset_n ? sel_a : FWD_GRF;
    fwd_sel_b = reset_n ? sel_b : FWD_GRF;
  end

`ifdef D_BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (stall_int && stall_cnt != '1) stall_cnt <= stall_cnt + STAT_W'(1);
      if (cmp_int && cmp_branch && taken_cnt != '1) taken_cnt <= taken_cnt + STAT_W'(1);
    end
  end
`endif

endmodule
